// File: rtl/key_pkg.sv
// Shared types and key index constants for the key_debounce block.
package key_pkg;

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } key_st_t;

  localparam int unsigned KEY_RIGHT = 0;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_FIRE  = 2;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM and press/release strobes.
// Auto-repeat on long hold is built only when KEY_AUTOREPEAT_EN is defined.
import key_pkg::*;

module key_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_rel
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             s;
  key_st_t          st_q;
  key_st_t          st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;
  logic             rel_d;
  logic             state_d;
  logic             rpt_d;

  // Pin synchronizer; resets to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // The sample that leaves a stable state counts as the first stable cycle.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (st_q)
      REL: begin
        if (s) begin
          st_d  = REL_CHK;
          cnt_d = CNT_ONE;
        end
      end
      REL_CHK: begin
        if (!s) begin
          st_d  = REL;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          st_d    = PRS;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRS: begin
        if (!s) begin
          st_d  = PRS_CHK;
          cnt_d = CNT_ONE;
        end
      end
      PRS_CHK: begin
        if (s) begin
          st_d  = PRS;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          st_d  = REL;
          cnt_d = '0;
          rel_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        st_d  = REL;
        cnt_d = '0;
      end
    endcase
  end

  assign state_d = (st_d == PRS) || (st_d == PRS_CHK);

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned HOLD_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  // Hold timer: runs only in steady PRS, freezes during PRS_CHK, clears on release.
  always_comb begin
    hold_d = hold_q;
    rpt_d  = 1'b0;
    if ((st_q == PRS) && s) begin
      if (hold_q == HOLD_LAST) begin
        rpt_d  = 1'b1;
        hold_d = HOLD_RELOAD;
      end else begin
        hold_d = hold_q + HOLD_ONE;
      end
    end
    if (st_d == REL) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign rpt_d = 1'b0;
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= REL;
      cnt_q     <= '0;
      key_state <= 1'b0;
      key_press <= 1'b0;
      key_rel   <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      key_state <= state_d;
      key_press <= press_d | rpt_d;
      key_rel   <= rel_d;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS active-low push-button pins into clean levels and strobes.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat press strobes.
import key_pkg::*;

module key_debounce #(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n_i,
  output logic [N_KEYS-1:0] key_state_o,
  output logic [N_KEYS-1:0] key_press_o,
  output logic [N_KEYS-1:0] key_rel_o
);

  // Fully independent channel per key.
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_n    (key_n_i[k]),
      .key_state(key_state_o[k]),
      .key_press(key_press_o[k]),
      .key_rel  (key_rel_o[k])
    );
  end

endmodule
